// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N packet requesters.
// Optional channel tag byte precedes each packet; stalled grants are released by an idle timeout.
module uart_tx_arbiter #(
   parameter int unsigned N            = 4,
   parameter int unsigned TAG_EN       = 1,
   parameter logic [7:0]  TAG_BASE     = 8'hF0,
   parameter int unsigned IDLE_TIMEOUT = 255,
   localparam int unsigned GW          = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [8*N-1:0]  req__data,
   input  logic [N-1:0]    req__valid,
   input  logic [N-1:0]    req__last,
   output logic [N-1:0]    req__ready,
   output logic [7:0]      uart__data,
   output logic            uart__valid,
   input  logic            uart__ready,
   output logic [GW-1:0]   grant__id,
   output logic            busy,
   output logic            abort
);

   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TAG  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            abort_q, abort_d;

   logic [GW-1:0]   pick;
   logic            pick_ok;
   logic [GW-1:0]   idx;
   logic [7:0]      sel_data;
   logic            sel_valid;
   logic            sel_last;
   logic [N-1:0]    grant_oh;

   // Rotating priority: first valid requester after ptr, wrapping modulo N.
   always_comb begin : arb_pick
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = GW'((32'(ptr_q) + k) % N);
         if (!pick_ok && req__valid[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   always_comb begin : grant_mux
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      grant_oh  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (GW'(i) == grant_q) begin
            sel_data    = req__data[8*i +: 8];
            sel_valid   = req__valid[i];
            sel_last    = req__last[i];
            grant_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin : fsm_next
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      abort_d     = 1'b0;
      uart__valid = 1'b0;
      uart__data  = '0;
      req__ready  = '0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (pick_ok) begin
               grant_d = pick;
               state_d = (TAG_EN != 0) ? S_TAG : S_DATA;
            end
         end
         S_TAG: begin
            uart__valid = 1'b1;
            uart__data  = TAG_BASE | 8'(grant_q);
            if (uart__ready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            uart__valid = sel_valid;
            uart__data  = sel_data;
            req__ready  = grant_oh & {N{uart__ready}};
            if (sel_valid) begin
               cnt_d = '0;
               if (uart__ready && sel_last) begin
                  ptr_d   = grant_q;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               // A requester that goes quiet mid-packet loses the grant.
               if ((IDLE_TIMEOUT != 0) && (cnt_d == CW'(IDLE_TIMEOUT))) begin
                  abort_d = 1'b1;
                  ptr_d   = grant_q;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin : fsm_reg
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= GW'(N - 1);
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   assign grant__id = grant_q;
   assign busy      = (state_q != S_IDLE);
   assign abort     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters and a simple UART ready model.
module tb_uart_tx_arbiter;

   localparam int FRAME = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [31:0] a_req_data  = '0;
   logic [3:0]  a_req_valid = '0;
   logic [3:0]  a_req_last  = '0;
   logic [3:0]  a_req_ready;
   logic [7:0]  a_uart_data;
   logic        a_uart_valid;
   logic        a_uart_ready = 1'b1;
   logic [1:0]  a_grant;
   logic        a_busy, a_abort;

   logic [31:0] b_req_data  = '0;
   logic [3:0]  b_req_valid = '0;
   logic [3:0]  b_req_last  = '0;
   logic [3:0]  b_req_ready;
   logic [7:0]  b_uart_data;
   logic        b_uart_valid;
   logic        b_uart_ready = 1'b1;
   logic [1:0]  b_grant;
   logic        b_busy, b_abort;

   bit [8:0]    rq_a [4][$];
   bit [8:0]    rq_b [4][$];
   logic [7:0]  a_log [$];
   logic [7:0]  b_log [$];
   int          a_ucnt = 0, b_ucnt = 0;
   bit          a_xp = 0, b_xp = 0;
   logic [3:0]  a_pop = '0, b_pop = '0;
   int          b_rdy_cnt = 0;
   logic [3:0]  b_rdy_val = '0;

   int total = 0;
   int bad   = 0;

   uart_tx_arbiter #(.N(4), .TAG_EN(1), .TAG_BASE(8'hF0), .IDLE_TIMEOUT(10)) dut_a (
      .clk(clk), .rst(rst),
      .req__data(a_req_data), .req__valid(a_req_valid), .req__last(a_req_last),
      .req__ready(a_req_ready),
      .uart__data(a_uart_data), .uart__valid(a_uart_valid), .uart__ready(a_uart_ready),
      .grant__id(a_grant), .busy(a_busy), .abort(a_abort)
   );

   uart_tx_arbiter #(.N(4), .TAG_EN(0), .TAG_BASE(8'hF0), .IDLE_TIMEOUT(0)) dut_b (
      .clk(clk), .rst(rst),
      .req__data(b_req_data), .req__valid(b_req_valid), .req__last(b_req_last),
      .req__ready(b_req_ready),
      .uart__data(b_uart_data), .uart__valid(b_uart_valid), .uart__ready(b_uart_ready),
      .grant__id(b_grant), .busy(b_busy), .abort(b_abort)
   );

   always #5 clk = ~clk;

   // Requesters and UART model update at negedge; the transfer at the next posedge is logged here.
   always @(negedge clk) begin
      bit [8:0] e;
      if (a_xp) a_ucnt = FRAME; else if (a_ucnt > 0) a_ucnt--;
      if (b_xp) b_ucnt = FRAME; else if (b_ucnt > 0) b_ucnt--;
      for (int i = 0; i < 4; i++) begin
         if (a_pop[i] && rq_a[i].size() > 0) void'(rq_a[i].pop_front());
         if (b_pop[i] && rq_b[i].size() > 0) void'(rq_b[i].pop_front());
         e = (rq_a[i].size() > 0) ? rq_a[i][0] : 9'h000;
         a_req_valid[i]       = (rq_a[i].size() > 0);
         a_req_data[8*i +: 8] = e[7:0];
         a_req_last[i]        = e[8];
         e = (rq_b[i].size() > 0) ? rq_b[i][0] : 9'h000;
         b_req_valid[i]       = (rq_b[i].size() > 0);
         b_req_data[8*i +: 8] = e[7:0];
         b_req_last[i]        = e[8];
      end
      a_uart_ready = (a_ucnt == 0);
      b_uart_ready = (b_ucnt == 0);
      #1;
      a_xp  = a_uart_valid && a_uart_ready && !rst;
      b_xp  = b_uart_valid && b_uart_ready && !rst;
      if (a_xp) a_log.push_back(a_uart_data);
      if (b_xp) b_log.push_back(b_uart_data);
      a_pop = a_req_valid & a_req_ready & {4{!rst}};
      b_pop = b_req_valid & b_req_ready & {4{!rst}};
      if (b_req_ready != 4'b0000) begin
         b_rdy_cnt++;
         b_rdy_val = b_req_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input logic [7:0] got [$], input logic [7:0] exp [$]);
      check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size() && k < got.size(); k++)
         check($sformatf("%s_%0d", tag, k), 32'(got[k]), 32'(exp[k]));
   endtask

   task automatic run_a(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (a_log.size() >= n && !a_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] exp [$];
      bit ok;
      bit seen_busy;
      int bad_s, lows, aborts;
      logic busy_at_abort;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_a_busy",  32'(a_busy), 32'(0));
      check("rst_a_valid", 32'(a_uart_valid), 32'(0));
      check("rst_a_grant", 32'(a_grant), 32'(0));
      check("rst_a_abort", 32'(a_abort), 32'(0));
      check("rst_a_ready", 32'(a_req_ready), 32'(0));
      check("rst_b_busy",  32'(b_busy), 32'(0));
      rst = 1'b0;
      tick();

      // req0 three-byte packet
      a_log.delete();
      rq_a[0].push_back({1'b0, 8'h41});
      rq_a[0].push_back({1'b0, 8'h42});
      rq_a[0].push_back({1'b1, 8'h43});
      seen_busy = 1'b0; bad_s = 0; ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (a_busy) seen_busy = 1'b1;
         if (seen_busy && a_log.size() < 4 && (!a_busy || a_grant != 2'd0)) bad_s++;
         if (a_log.size() >= 4 && !a_busy) begin ok = 1'b1; break; end
      end
      check("t1_done", 32'(ok), 32'(1));
      check("t1_held", 32'(bad_s), 32'(0));
      exp = '{8'hF0, 8'h41, 8'h42, 8'h43};
      check_log("t1", a_log, exp);

      // All four requesters, two single-byte packets each, ptr = 0
      a_log.delete();
      for (int i = 0; i < 4; i++) begin
         rq_a[i].push_back({1'b1, 8'hC0 + 8'(i)});
         rq_a[i].push_back({1'b1, 8'hD0 + 8'(i)});
      end
      run_a(16, 500, ok);
      check("t3_done", 32'(ok), 32'(1));
      exp = '{8'hF1, 8'hC1, 8'hF2, 8'hC2, 8'hF3, 8'hC3, 8'hF0, 8'hC0,
              8'hF1, 8'hD1, 8'hF2, 8'hD2, 8'hF3, 8'hD3, 8'hF0, 8'hD0};
      check_log("t3", a_log, exp);

      // req1 and req3 simultaneously with ptr = 0
      a_log.delete();
      rq_a[1].push_back({1'b0, 8'hA1});
      rq_a[1].push_back({1'b1, 8'hA2});
      rq_a[3].push_back({1'b1, 8'hB1});
      run_a(5, 300, ok);
      check("t2_done", 32'(ok), 32'(1));
      exp = '{8'hF1, 8'hA1, 8'hA2, 8'hF3, 8'hB1};
      check_log("t2", a_log, exp);

      // Idle timeout of 10 with req1 pending
      a_log.delete();
      rq_a[0].push_back({1'b0, 8'h10});
      for (int c = 0; c < 100 && a_log.size() < 2; c++) tick();
      rq_a[1].push_back({1'b1, 8'h77});
      lows = 0; aborts = 0; busy_at_abort = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (!a_req_valid[0]) lows++;
         if (a_abort) begin
            aborts++;
            busy_at_abort = a_busy;
            break;
         end
      end
      check("to_lows",  32'(lows), 32'(10));
      check("to_abort", 32'(aborts), 32'(1));
      check("to_idle",  32'(busy_at_abort), 32'(0));
      tick();
      check("to_regrant_id",   32'(a_grant), 32'(1));
      check("to_regrant_busy", 32'(a_busy), 32'(1));
      check("to_abort_once",   32'(a_abort), 32'(0));
      run_a(4, 200, ok);
      check("to_done", 32'(ok), 32'(1));
      exp = '{8'hF0, 8'h10, 8'hF1, 8'h77};
      check_log("to", a_log, exp);

      // Reset mid-frame during DATA of req2
      a_log.delete();
      rq_a[2].push_back({1'b0, 8'h31});
      rq_a[2].push_back({1'b0, 8'h32});
      rq_a[2].push_back({1'b1, 8'h33});
      for (int c = 0; c < 100 && a_log.size() < 2; c++) tick();
      rq_a[2].delete();
      rst = 1'b1;
      tick();
      check("mr_busy",  32'(a_busy), 32'(0));
      check("mr_valid", 32'(a_uart_valid), 32'(0));
      check("mr_grant", 32'(a_grant), 32'(0));
      rst = 1'b0;
      rq_a[0].push_back({1'b1, 8'h61});
      rq_a[2].push_back({1'b1, 8'h62});
      run_a(6, 300, ok);
      check("mr_done", 32'(ok), 32'(1));
      exp = '{8'hF2, 8'h31, 8'hF0, 8'h61, 8'hF2, 8'h62};
      check_log("mr", a_log, exp);

      // TAG_EN = 0, req2 single byte
      b_log.delete();
      b_rdy_cnt = 0;
      rq_b[2].push_back({1'b1, 8'h55});
      repeat (20) tick();
      check("nt_len",      32'(b_log.size()), 32'(1));
      check("nt_byte",     32'(b_log.size() > 0 ? b_log[0] : 8'h00), 32'(8'h55));
      check("nt_rdy_cnt",  32'(b_rdy_cnt), 32'(1));
      check("nt_rdy_val",  32'(b_rdy_val), 32'(4'b0100));
      check("nt_idle",     32'(b_busy), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
